z_run_monitor: RTL and testbench

- Downstream consumer of the lab's 4-in-a-row sequence-detector FSM; samples the detector output z on every rising edge of KEY0.
- Counts detection events, which are separate runs of z=1.
- Measures the length of the current z=1 run and retains the last and longest run lengths.
- Drives LEDR/HEX-level status for the board top.

---
 rtl/z_run_monitor_pkg.sv | 51 +++++
 rtl/z_run_monitor_hex7seg.sv | 13 +
 rtl/z_run_monitor.sv | 128 ++++++++++++
 tb/tb_z_run_monitor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/z_run_monitor_pkg.sv
// rtl/z_run_monitor_pkg.sv - shared state encoding, default widths and 7-segment glyphs for z_run_monitor
package z_run_monitor_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int CNT_W_DEF = 8;
    localparam int RUN_W_DEF = 8;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble);
        case (nibble)
            4'h0: seg7_glyph = SEG_0;
            4'h1: seg7_glyph = SEG_1;
            4'h2: seg7_glyph = SEG_2;
            4'h3: seg7_glyph = SEG_3;
            4'h4: seg7_glyph = SEG_4;
            4'h5: seg7_glyph = SEG_5;
            4'h6: seg7_glyph = SEG_6;
            4'h7: seg7_glyph = SEG_7;
            4'h8: seg7_glyph = SEG_8;
            4'h9: seg7_glyph = SEG_9;
            4'hA: seg7_glyph = SEG_A;
            4'hB: seg7_glyph = SEG_B;
            4'hC: seg7_glyph = SEG_C;
            4'hD: seg7_glyph = SEG_D;
            4'hE: seg7_glyph = SEG_E;
            default: seg7_glyph = SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/z_run_monitor_hex7seg.sv
// rtl/z_run_monitor_hex7seg.sv - one hex digit to active-low 7-segment decoder
module hex7seg
    import z_run_monitor_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg7_glyph(nibble);
    end

endmodule

// File: rtl/z_run_monitor.sv
// rtl/z_run_monitor.sv - counts and measures runs of z=1; HEX outputs under Z_RUN_MONITOR_SEG7_EN
module z_run_monitor
    import z_run_monitor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int RUN_W = RUN_W_DEF
) (
    input  logic             KEY0,
    input  logic             SW0,
    input  logic             z,
    input  logic             clr,
    output logic             active,
    output logic [CNT_W-1:0] event_count,
    output logic [RUN_W-1:0] run_len,
    output logic [RUN_W-1:0] last_run,
    output logic [RUN_W-1:0] max_run,
`ifdef Z_RUN_MONITOR_SEG7_EN
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
`endif
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};

    state_t           state, next_state;
    logic [CNT_W-1:0] event_count_d;
    logic [RUN_W-1:0] run_len_d, last_run_d, max_run_d;
    logic             ovf_d;

    always_ff @(posedge KEY0 or negedge SW0) begin
        if (!SW0) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Any state other than a valid one falls back to S_IDLE
    always_comb begin
        next_state = S_IDLE;
        if (!clr) begin
            case (state)
                S_IDLE:  next_state = z ? S_RUN : S_IDLE;
                S_RUN:   next_state = z ? S_RUN : S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        event_count_d = event_count;
        run_len_d     = run_len;
        last_run_d    = last_run;
        max_run_d     = max_run;
        ovf_d         = ovf;
        if (clr) begin
            event_count_d = '0;
            run_len_d     = '0;
            last_run_d    = '0;
            max_run_d     = '0;
            ovf_d         = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (z) begin
                        run_len_d = {{(RUN_W-1){1'b0}}, 1'b1};
                        if (event_count == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            event_count_d = event_count + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (z) begin
                        if (run_len == RUN_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            run_len_d = run_len + 1'b1;
                        end
                    end else begin
                        last_run_d = run_len;
                        if (run_len > max_run) begin
                            max_run_d = run_len;
                        end
                    end
                end
                default: begin
                    run_len_d = run_len;
                end
            endcase
        end
    end

    always_ff @(posedge KEY0 or negedge SW0) begin
        if (!SW0) begin
            event_count <= '0;
            run_len     <= '0;
            last_run    <= '0;
            max_run     <= '0;
            ovf         <= 1'b0;
        end else begin
            event_count <= event_count_d;
            run_len     <= run_len_d;
            last_run    <= last_run_d;
            max_run     <= max_run_d;
            ovf         <= ovf_d;
        end
    end

    assign active = (state == S_RUN);

`ifdef Z_RUN_MONITOR_SEG7_EN
    logic [7:0] ec8, mr8;
    assign ec8 = 8'(event_count);
    assign mr8 = 8'(max_run);

    hex7seg u_hex0 (.nibble(ec8[3:0]), .seg(HEX0));
    hex7seg u_hex1 (.nibble(ec8[7:4]), .seg(HEX1));
    hex7seg u_hex2 (.nibble(mr8[3:0]), .seg(HEX2));
    hex7seg u_hex3 (.nibble(mr8[7:4]), .seg(HEX3));
`endif

endmodule

// File: tb/tb_z_run_monitor.sv
// tb/tb_z_run_monitor.sv - scoreboard bench for z_run_monitor (RUN_W=4); HEX checks under Z_RUN_MONITOR_SEG7_EN
module tb_z_run_monitor;

    localparam int CW = 8;
    localparam int RW = 4;

    logic          KEY0 = 1'b0;
    logic          SW0  = 1'b0;
    logic          z    = 1'b0;
    logic          clr  = 1'b0;
    logic          active;
    logic [CW-1:0] event_count;
    logic [RW-1:0] run_len, last_run, max_run;
    logic          ovf;
`ifdef Z_RUN_MONITOR_SEG7_EN
    logic [6:0]    HEX0, HEX1, HEX2, HEX3;
`endif

    z_run_monitor #(.CNT_W(CW), .RUN_W(RW)) dut (
        .KEY0        (KEY0),
        .SW0         (SW0),
        .z           (z),
        .clr         (clr),
        .active      (active),
        .event_count (event_count),
        .run_len     (run_len),
        .last_run    (last_run),
        .max_run     (max_run),
`ifdef Z_RUN_MONITOR_SEG7_EN
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3),
`endif
        .ovf         (ovf)
    );

    always #5 KEY0 = ~KEY0;

    typedef struct packed {
        logic          act;
        logic [CW-1:0] ec;
        logic [RW-1:0] rl;
        logic [RW-1:0] last;
        logic [RW-1:0] mx;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    logic          m_run;
    logic [CW-1:0] m_ec;
    logic [RW-1:0] m_rl, m_last, m_max;
    logic          m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_ec = '0; m_rl = '0; m_last = '0; m_max = '0; m_ovf = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_active"}, {31'd0, active}, 32'd0);
        check({tag, "_ec"},     {24'd0, event_count}, 32'd0);
        check({tag, "_rl"},     {28'd0, run_len}, 32'd0);
        check({tag, "_last"},   {28'd0, last_run}, 32'd0);
        check({tag, "_max"},    {28'd0, max_run}, 32'd0);
        check({tag, "_ovf"},    {31'd0, ovf}, 32'd0);
    endtask

    // Called just after a falling edge; returns just after the next falling edge
    task automatic cycle(input logic z_v, input logic clr_v);
        exp_t e;
        z   = z_v;
        clr = clr_v;
        if (clr_v) begin
            model_reset();
        end else if (!m_run) begin
            if (z_v) begin
                m_run = 1'b1;
                m_rl  = 1;
                if (m_ec == {CW{1'b1}}) m_ovf = 1'b1;
                else m_ec = m_ec + 1'b1;
            end
        end else begin
            if (z_v) begin
                if (m_rl == {RW{1'b1}}) m_ovf = 1'b1;
                else m_rl = m_rl + 1'b1;
            end else begin
                m_run  = 1'b0;
                m_last = m_rl;
                if (m_rl > m_max) m_max = m_rl;
            end
        end
        exp_q.push_back('{m_run, m_ec, m_rl, m_last, m_max, m_ovf});
        @(posedge KEY0);
        #1;
        e = exp_q.pop_front();
        check("sb_active", {31'd0, active}, {31'd0, e.act});
        check("sb_ec",     {24'd0, event_count}, {24'd0, e.ec});
        check("sb_rl",     {28'd0, run_len}, {28'd0, e.rl});
        check("sb_last",   {28'd0, last_run}, {28'd0, e.last});
        check("sb_max",    {28'd0, max_run}, {28'd0, e.mx});
        check("sb_ovf",    {31'd0, ovf}, {31'd0, e.ovf});
        @(negedge KEY0);
    endtask

    initial begin
        int act_cnt;
        model_reset();
        repeat (2) @(negedge KEY0);
        check_zero("reset");
        SW0 = 1'b1;

        // Reset asserted between edges during a run
        repeat (3) cycle(1'b1, 1'b0);
        check("pre_rst_active", {31'd0, active}, 32'd1);
        #2 SW0 = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        z = 1'b0;
        @(negedge KEY0);
        check_zero("rst_hold");
        SW0 = 1'b1;

        // Single run of 5
        act_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0);
            if (active) act_cnt++;
        end
        cycle(1'b0, 1'b0);
        check("single_active_cycles", act_cnt, 32'd5);
        check("single_active_end", {31'd0, active}, 32'd0);
        check("single_ec",   {24'd0, event_count}, 32'd1);
        check("single_rl",   {28'd0, run_len}, 32'd5);
        check("single_last", {28'd0, last_run}, 32'd5);
        check("single_max",  {28'd0, max_run}, 32'd5);

        // Runs of 6 and 2 with one idle cycle between
        cycle(1'b0, 1'b1);
        check_zero("clr_idle");
        repeat (6) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("two_ec",   {24'd0, event_count}, 32'd2);
        check("two_last", {28'd0, last_run}, 32'd2);
        check("two_max",  {28'd0, max_run}, 32'd6);

        // clr coincident with z=1 mid-run
        repeat (2) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check_zero("clr_z");
        repeat (2) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("clrz_ec",  {24'd0, event_count}, 32'd1);
        check("clrz_rl",  {28'd0, run_len}, 32'd2);
        check("clrz_max", {28'd0, max_run}, 32'd2);

        // Run-length saturation
        cycle(1'b0, 1'b1);
        repeat (20) cycle(1'b1, 1'b0);
        check("sat_rl",  {28'd0, run_len}, 32'd15);
        check("sat_ovf", {31'd0, ovf}, 32'd1);
        cycle(1'b0, 1'b0);
        check("sat_max",  {28'd0, max_run}, 32'd15);
        check("sat_last", {28'd0, last_run}, 32'd15);
        repeat (3) cycle(1'b0, 1'b0);
        check("sat_ovf_sticky", {31'd0, ovf}, 32'd1);
        cycle(1'b0, 1'b1);
        check("sat_ovf_clr", {31'd0, ovf}, 32'd0);

        // Event-count saturation
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
        end
        check("ec_sat",     {24'd0, event_count}, 32'd255);
        check("ec_sat_ovf", {31'd0, ovf}, 32'd1);

`ifdef Z_RUN_MONITOR_SEG7_EN
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 57; i++) begin
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
        end
        repeat (7) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("seg_ec",  {24'd0, event_count}, 32'h3A);
        check("seg_max", {28'd0, max_run}, 32'h07);
        check("hex0", {25'd0, HEX0}, {25'd0, 7'b0001000});
        check("hex1", {25'd0, HEX1}, {25'd0, 7'b0110000});
        check("hex2", {25'd0, HEX2}, {25'd0, 7'b1111000});
        check("hex3", {25'd0, HEX3}, {25'd0, 7'b1000000});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
